// File: rtl/sweep_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sweep_sequencer_pkg
// Shared constants and types for the environment write-back sweep.
//   DEF_*        : default grid size and settle window (640x480 screen, 4x4
//                  pixel cells -> 160x120 grid)
//   sweep_state_t: sequencer state encoding
//   cnt_width()  : width of the settle down-counter for a given window
// -----------------------------------------------------------------------------
package sweep_sequencer_pkg;

  localparam int unsigned DEF_X_MAX         = 159;  // (640 >> 2) - 1
  localparam int unsigned DEF_Y_MAX         = 119;  // (480 >> 2) - 1
  localparam int unsigned DEF_X_BITS        = 8;
  localparam int unsigned DEF_Y_BITS        = 7;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  // A one-cycle window still needs a 1-bit counter that only ever holds 0.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/sweep_sequencer_key_edge_sync.sv
// -----------------------------------------------------------------------------
// key_edge_sync
// Two-flop synchroniser for an active-low push button, followed by a
// falling-edge detector (one-cycle pulse per press).
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_key_n : raw button, low while pressed
//   o_fall  : one-cycle pulse on each synchronised press
// -----------------------------------------------------------------------------
module key_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to the released level so that leaving reset never looks
  // like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, which is what builds the shift chain.
      r_meta <= i_key_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/sweep_sequencer.sv
// -----------------------------------------------------------------------------
// sweep_sequencer
// Walks writeLoc over every grid cell in raster order once per game tick,
// holding each cell for a settle window before a one-cycle write_flag.
//   newLocClock : clock (rising edge)
//   RESET_SIM   : synchronous active-high reset
//   game_tick   : slow tick level; a sweep starts on its rising edge
//   RUN         : high when not in setup mode; low aborts a sweep
//   KEY_PAUSE   : raw active-low button; each press toggles pause
//   writeLoc_x/y: current write cell
//   write_flag  : commit strobe for the current cell
//   hold_locs   : coordinates must not change (IDLE, SETTLE, WRITE)
//   sweep_busy  : sweep in progress, including the DONE cycle
//   sweep_done  : one-cycle pulse after the last cell's write
//   paused      : current pause state
//   overrun     : sticky; a tick arrived while busy
//   frame_count : completed sweeps, wraps modulo 2^16
// -----------------------------------------------------------------------------
module sweep_sequencer
  import sweep_sequencer_pkg::*;
#(
  parameter int unsigned X_MAX         = DEF_X_MAX,
  parameter int unsigned Y_MAX         = DEF_Y_MAX,
  parameter int unsigned X_BITS        = DEF_X_BITS,
  parameter int unsigned Y_BITS        = DEF_Y_BITS,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              newLocClock,
  input  logic              RESET_SIM,
  input  logic              game_tick,
  input  logic              RUN,
  input  logic              KEY_PAUSE,
  output logic [X_BITS-1:0] writeLoc_x,
  output logic [Y_BITS-1:0] writeLoc_y,
  output logic              write_flag,
  output logic              hold_locs,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              paused,
  output logic              overrun,
  output logic [15:0]       frame_count
);

  localparam int unsigned             CNT_BITS = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_BITS-1:0]     CNT_LOAD = CNT_BITS'(SETTLE_CYCLES - 1);
  localparam logic [X_BITS-1:0]       X_LAST   = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0]       Y_LAST   = Y_BITS'(Y_MAX);

  sweep_state_t        r_state;
  logic [X_BITS-1:0]   r_x;
  logic [Y_BITS-1:0]   r_y;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_tick_q;
  logic                r_paused;
  logic                r_overrun;
  logic [15:0]         r_frame;

  sweep_state_t        w_state_nxt;
  logic [X_BITS-1:0]   w_x_nxt;
  logic [Y_BITS-1:0]   w_y_nxt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [15:0]         w_frame_nxt;
  logic                w_overrun_nxt;
  logic                w_write;
  logic                w_done;
  logic                w_hold;
  logic                w_busy;
  logic                w_tick_rise;
  logic                w_key_fall;

  key_edge_sync u_pause_key (
    .i_clk   (newLocClock),
    .i_rst   (RESET_SIM),
    .i_key_n (KEY_PAUSE),
    .o_fall  (w_key_fall)
  );

  // game_tick comes from clock_cutter in the same clock domain, so a single
  // history flop is enough for edge detection.
  assign w_tick_rise = game_tick & ~r_tick_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = r_frame;
    w_write     = 1'b0;
    w_done      = 1'b0;
    w_hold      = 1'b1;
    w_busy      = 1'b1;

    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        // Ticks seen while paused or in setup are simply dropped.
        if (w_tick_rise && RUN && !r_paused) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        if (!RUN) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = WRITE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_BITS'(1);
        end
      end

      WRITE: begin
        if (!RUN) begin
          // Aborted sweep: no commit for this cell, no frame counted.
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = IDLE;
        end else begin
          w_write = 1'b1;
          if (r_x == X_LAST && r_y == Y_LAST) begin
            w_state_nxt = DONE;
          end else begin
            if (r_x == X_LAST) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + Y_BITS'(1);
            end else begin
              w_x_nxt = r_x + X_BITS'(1);
            end
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = SETTLE;
          end
        end
      end

      DONE: begin
        w_hold      = 1'b0;
        w_done      = 1'b1;
        w_frame_nxt = r_frame + 16'd1;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // DONE still counts as busy, so a tick landing there is an overrun.
    w_overrun_nxt = r_overrun | (w_tick_rise & w_busy);
  end

  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_tick_q  <= 1'b0;
      r_paused  <= 1'b0;
      r_overrun <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tick_q  <= game_tick;
      r_paused  <= r_paused ^ w_key_fall;
      r_overrun <= w_overrun_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  // Strobes are masked while RESET_SIM is asserted so that a reset landing
  // on a WRITE or DONE cycle never commits a cell or counts a frame
  // downstream.
  assign write_flag  = w_write & ~RESET_SIM;
  assign sweep_done  = w_done & ~RESET_SIM;
  assign sweep_busy  = w_busy & ~RESET_SIM;
  assign hold_locs   = w_hold | RESET_SIM;
  assign writeLoc_x  = r_x;
  assign writeLoc_y  = r_y;
  assign paused      = r_paused;
  assign overrun     = r_overrun;
  assign frame_count = r_frame;

endmodule

// File: tb/tb_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sweep_sequencer
// Scoreboard bench on a 4x3 grid with a 2-cycle settle window. Expected
// writes (cell and cycle) and sweep_done cycles are queued when a sweep is
// started and compared on the falling edge whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_sweep_sequencer;

  localparam int unsigned TB_X_MAX  = 3;
  localparam int unsigned TB_Y_MAX  = 2;
  localparam int unsigned TB_SETTLE = 2;
  localparam int unsigned N_CELLS   = (TB_X_MAX + 1) * (TB_Y_MAX + 1);

  logic       clk;
  logic       rst;
  logic       game_tick;
  logic       run;
  logic       key_pause;
  logic [7:0] loc_x;
  logic [6:0] loc_y;
  logic       write_flag;
  logic       hold_locs;
  logic       sweep_busy;
  logic       sweep_done;
  logic       paused;
  logic       overrun;
  logic [15:0] frame_count;

  sweep_sequencer #(
    .X_MAX         (TB_X_MAX),
    .Y_MAX         (TB_Y_MAX),
    .X_BITS        (8),
    .Y_BITS        (7),
    .SETTLE_CYCLES (TB_SETTLE)
  ) dut (
    .newLocClock (clk),
    .RESET_SIM   (rst),
    .game_tick   (game_tick),
    .RUN         (run),
    .KEY_PAUSE   (key_pause),
    .writeLoc_x  (loc_x),
    .writeLoc_y  (loc_y),
    .write_flag  (write_flag),
    .hold_locs   (hold_locs),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .paused      (paused),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int cyc;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int      done_q[$];
  int      n_checks = 0;
  int      n_pass   = 0;
  int      exp_frames = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Monitor: compare every strobe against the scoreboard.
  always @(negedge clk) begin
    if (write_flag === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", write_flag, 0);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check("wr_x", loc_x, e.x);
        check("wr_y", loc_y, e.y);
        check("wr_cycle", cyc, e.cyc);
        check("wr_hold", hold_locs, 1);
      end
    end
    if (sweep_done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", sweep_done, 0);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
        check("done_busy", sweep_busy, 1);
        exp_frames++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the first n_writes cells of a sweep whose tick_rise is in cycle t;
  // the done pulse is queued only for a full sweep.
  task automatic push_sweep(input int t, input int n_writes);
    int k;
    k = 0;
    for (int y = 0; y <= int'(TB_Y_MAX); y++) begin
      for (int x = 0; x <= int'(TB_X_MAX); x++) begin
        if (k < n_writes) begin
          wr_exp_t e;
          e.x   = x;
          e.y   = y;
          e.cyc = t + 1 + int'(TB_SETTLE) + k * int'(TB_SETTLE + 1);
          wr_q.push_back(e);
        end
        k++;
      end
    end
    if (n_writes == int'(N_CELLS))
      done_q.push_back(t + 1 + int'(TB_SETTLE) + (n_writes - 1) * int'(TB_SETTLE + 1) + 1);
  endtask

  // Raise game_tick in the current cycle (returns 2 cycles later, tick low).
  task automatic start_sweep(output int t, input int n_writes);
    t = cyc;
    game_tick = 1'b1;
    push_sweep(t, n_writes);
    step(2);
    game_tick = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 200;
    while (done_q.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    check("done_timeout", done_q.size(), 0);
    check("wr_drained", wr_q.size(), 0);
    check("frame_count", frame_count, exp_frames);
    check("idle_after_done", sweep_busy, 0);
  endtask

  task automatic press_pause();
    key_pause = 1'b0;
    step(3);
    key_pause = 1'b1;
    step(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_frames = 0;
    step(2);
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    game_tick = 1'b0;
    run       = 1'b1;
    key_pause = 1'b1;
    step(1);

    // Reset then idle.
    do_reset();
    step(4);
    check("rst_x", loc_x, 0);
    check("rst_y", loc_y, 0);
    check("rst_write_flag", write_flag, 0);
    check("rst_hold", hold_locs, 1);
    check("rst_busy", sweep_busy, 0);
    check("rst_done", sweep_done, 0);
    check("rst_paused", paused, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frames", frame_count, 0);

    // One full sweep.
    start_sweep(t, N_CELLS);
    check("sweep_busy", sweep_busy, 1);
    wait_done();
    check("sweep_no_overrun", overrun, 0);
    step(3);

    // Overrun: second tick 10 cycles into the sweep.
    start_sweep(t, N_CELLS);
    step(8);
    game_tick = 1'b1;
    step(1);
    check("overrun_set", overrun, 1);
    step(2);
    game_tick = 1'b0;
    wait_done();
    step(30);
    check("overrun_sticky", overrun, 1);
    check("overrun_no_resweep", sweep_busy, 0);

    // Pause mid-sweep; sweep still completes.
    do_reset();
    check("reset_clears_overrun", overrun, 0);
    start_sweep(t, N_CELLS);
    step(3);
    press_pause();
    check("paused_mid_sweep", paused, 1);
    check("paused_busy", sweep_busy, 1);
    wait_done();
    check("paused_after_done", paused, 1);
    game_tick = 1'b1;
    step(2);
    game_tick = 1'b0;
    step(20);
    check("paused_tick_busy", sweep_busy, 0);
    check("paused_tick_overrun", overrun, 0);
    press_pause();
    check("unpaused", paused, 0);
    start_sweep(t, N_CELLS);
    wait_done();
    step(3);

    // RUN drop while at (2,1) in SETTLE.
    start_sweep(t, 6);
    step(17);
    check("rundrop_pre_x", loc_x, 2);
    check("rundrop_pre_y", loc_y, 1);
    check("rundrop_pre_busy", sweep_busy, 1);
    run = 1'b0;
    step(1);
    check("rundrop_busy", sweep_busy, 0);
    check("rundrop_x", loc_x, 0);
    check("rundrop_y", loc_y, 0);
    check("rundrop_hold", hold_locs, 1);
    step(20);
    check("rundrop_wr_drained", wr_q.size(), 0);
    check("rundrop_frames", frame_count, exp_frames);
    run = 1'b1;
    step(3);

    // Reset in the WRITE cycle of cell 4, with an overrun pending.
    start_sweep(t, 4);
    step(6);
    game_tick = 1'b1;
    step(2);
    game_tick = 1'b0;
    step(5);
    check("rstw_in_write_cycle", cyc, t + 15);
    check("rstw_overrun_before", overrun, 1);
    rst = 1'b1;
    step(1);
    check("rstw_write_flag", write_flag, 0);
    check("rstw_x", loc_x, 0);
    check("rstw_y", loc_y, 0);
    check("rstw_hold", hold_locs, 1);
    check("rstw_busy", sweep_busy, 0);
    check("rstw_overrun", overrun, 0);
    check("rstw_frames", frame_count, 0);
    check("rstw_paused", paused, 0);
    rst = 1'b0;
    exp_frames = 0;
    step(20);
    check("rstw_wr_drained", wr_q.size(), 0);
    check("rstw_idle", sweep_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
